mem_access_stage: RTL and testbench
===================================

MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 The block SHALL have one parameter: TIMEOUT_CYCLES, default 16, the number of WAIT cycles without dm_ack before a bus fault is raised (only used under MEM_TIMEOUT_EN).
REQ-002 The block SHALL use one clock; reset is synchronous and active-high.
REQ-003 Ports (name, direction, width, meaning):
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous active-high reset.
- valid  in  1  the current instruction is live.
- mem_read  in  1  load request.
- mem_write  in  1  store request.
- alu_result  in  64  effective address from the ALU.
- write_data  in  64  store data.
- stall  out  1  holds the PC and inputs stable while high.
- read_data  out  64  registered load data.
- done  out  1  one-cycle pulse marking the end of an access, successful or faulted.
- exc_misaligned  out  1  alignment fault pulse.
- exc_bus  out  1  bus-timeout fault pulse.
- exc_addr  out  64  faulting address, held until the next fault.
- dm_req  out  1  data-memory request.
- dm_we  out  1  data-memory write enable.
- dm_addr  out  64  data-memory address.
- dm_wdata  out  64  data-memory write data.
- dm_rdata  in  64  data-memory read data.
- dm_ack  in  1  one-cycle data-memory completion.

Function
REQ-004 The FSM SHALL have four states: IDLE, WAIT, DONE, FAULT.
REQ-005 Acceptance SHALL occur in IDLE when valid & (mem_read | mem_write); alu_result, write_data and the operation are latched at that edge.
REQ-006 At acceptance, if alu_result[2:0] != 0, the FSM SHALL go IDLE->FAULT with cause misaligned, and dm_req SHALL never assert.
REQ-007 At acceptance with an aligned address, the FSM SHALL go IDLE->WAIT, with dm_req=1, dm_addr and dm_wdata taken from the latched values, and dm_we=latched write.
REQ-008 If mem_read and mem_write are both high at acceptance, the write SHALL take priority and read_data SHALL be left unchanged.
REQ-009 In WAIT, dm_req SHALL stay high until the dm_ack cycle. On dm_ack:
- read_data<=dm_rdata if the op is a read;
- the FSM goes WAIT->DONE.
REQ-010 DONE and FAULT SHALL each last exactly one cycle, pulse done=1, then return to IDLE.
REQ-011 FAULT SHALL pulse exactly one of exc_misaligned/exc_bus and load exc_addr with the latched address.
REQ-012 stall SHALL be combinational: 1 in WAIT, and 1 in IDLE when an acceptance condition holds; 0 in DONE, FAULT, and idle without an access.
REQ-013 Minimum latency SHALL be: acceptance edge, ack in the first WAIT cycle, DONE on the next cycle, i.e. 2 cycles with stall high.
REQ-014 dm_ack SHALL be ignored in IDLE, DONE and FAULT.
REQ-015 valid with neither mem_read nor mem_write SHALL produce no dm_req, stall or done.
REQ-016 A new access SHALL NOT be accepted in DONE or FAULT; acceptance resumes in IDLE on the next cycle.

Reset
REQ-017 On reset the block SHALL go to IDLE. All outputs SHALL be 0 (read_data=0, exc_addr=0, dm_* outputs =0) on the cycle after the reset edge.
REQ-018 Reset asserted in WAIT SHALL abort the access: dm_req=0 next cycle, no done, no exception; a late dm_ack is then ignored.

Configuration
REQ-019 With MEM_TIMEOUT_EN defined:
- a WAIT-cycle counter SHALL clear on WAIT entry;
- when the count reaches TIMEOUT_CYCLES without dm_ack, the FSM SHALL go WAIT->FAULT with cause bus (exc_bus);
- dm_ack in the same cycle as the timeout SHALL win.
REQ-020 Without MEM_TIMEOUT_EN, WAIT SHALL persist indefinitely, exc_bus SHALL be tied 0, and no counter logic SHALL exist.

Structure
REQ-021 A shared package mem_pkg SHALL hold:
- the state enum;
- the fault-cause enum (NONE, MISALIGNED, BUS);
- the ALIGN_MASK constant 3'b111;
- the default TIMEOUT_CYCLES.
REQ-022 The timeout counter SHALL be one sub-module, mem_timeout, instantiated only under MEM_TIMEOUT_EN.

Verification
REQ-023 Load, addr 0x40, dm_ack in the 1st WAIT cycle with dm_rdata=0x1234 -> stall for 2 cycles, read_data=0x1234, done pulses once.
REQ-024 Store, addr 0x88, data 0xDEAD, ack after 3 WAIT cycles -> dm_we=1, dm_addr=0x88, dm_wdata=0xDEAD held for 3 cycles, done pulses once, read_data unchanged.
REQ-025 Load, addr 0x43 -> no dm_req, exc_misaligned pulse, exc_addr=0x43, stall for 1 cycle.
REQ-026 MEM_TIMEOUT_EN defined, TIMEOUT_CYCLES=4, no ack -> exc_bus pulses after 4 WAIT cycles, exc_addr set, FSM back in IDLE.
REQ-027 Reset in the 2nd WAIT cycle, then dm_ack -> IDLE, dm_req=0, no done or exception.
REQ-028 mem_read and mem_write both high, addr 0x10 -> write performed, read_data unchanged.

Source files
------------

// File: rtl/mem_pkg.sv
// ----------------------------------------------------------------------------
// mem_pkg
// Shared definitions for the memory-access pipeline stage:
//   - state_t  : access FSM states (IDLE, WAIT, DONE, FAULT)
//   - cause_t  : fault cause recorded when entering FAULT
//   - ALIGN_MASK : low address bits that must be zero for a 64-bit access
//   - DEFAULT_TIMEOUT_CYCLES : default WAIT-cycle budget before a bus fault
// ----------------------------------------------------------------------------
package mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DONE  = 2'd2,
    ST_FAULT = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    CAUSE_NONE       = 2'd0,
    CAUSE_MISALIGNED = 2'd1,
    CAUSE_BUS        = 2'd2
  } cause_t;

  localparam logic [2:0] ALIGN_MASK = 3'b111;

  localparam int DEFAULT_TIMEOUT_CYCLES = 16;

endpackage

// File: rtl/mem_timeout.sv
// ----------------------------------------------------------------------------
// mem_timeout
// Counts cycles spent waiting for the data memory and flags expiry.
// Only instantiated when the MEM_TIMEOUT_EN macro is defined.
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   clear      : restart the count (asserted on the edge that enters WAIT)
//   active     : the stage is currently in WAIT
//   expired    : this WAIT cycle is the TIMEOUT_CYCLES-th one without ack
// ----------------------------------------------------------------------------
module mem_timeout
  import mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic active,
  output logic expired
);

  // count_q holds the number of WAIT cycles already completed, so it never
  // needs to exceed TIMEOUT_CYCLES-1.
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  assign expired = active && (count_q == CW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (active && !expired) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/mem_access_stage.sv
// ----------------------------------------------------------------------------
// mem_access_stage
// Memory-access pipeline stage: accepts one load/store at a time, checks
// 8-byte alignment, runs a request/ack handshake with the data memory and
// reports completion or a fault.
// Optional feature: define MEM_TIMEOUT_EN to enable a bus-timeout fault
// after TIMEOUT_CYCLES WAIT cycles without dm_ack; otherwise WAIT lasts
// until dm_ack and exc_bus is tied low.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   valid, mem_read,
//   mem_write             : live instruction and its memory operation
//   alu_result, write_data: effective address and store data
//   stall                 : hold upstream while an access is in progress
//   read_data             : registered load data
//   done                  : one-cycle end-of-access pulse (ok or faulted)
//   exc_misaligned,
//   exc_bus, exc_addr     : fault pulses and held faulting address
//   dm_req/we/addr/wdata,
//   dm_rdata, dm_ack      : data-memory request/response
// ----------------------------------------------------------------------------
module mem_access_stage
  import mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [63:0] alu_result,
  input  logic [63:0] write_data,
  output logic        stall,
  output logic [63:0] read_data,
  output logic        done,
  output logic        exc_misaligned,
  output logic        exc_bus,
  output logic [63:0] exc_addr,
  output logic        dm_req,
  output logic        dm_we,
  output logic [63:0] dm_addr,
  output logic [63:0] dm_wdata,
  input  logic [63:0] dm_rdata,
  input  logic        dm_ack
);

  state_t      state_q, state_d;
  cause_t      cause_q, cause_d;
  logic        we_q, we_d;
  logic [63:0] addr_q, addr_d;
  logic [63:0] wdata_q, wdata_d;
  logic [63:0] exc_addr_q, exc_addr_d;
  logic [63:0] read_data_q, read_data_d;

  logic accept;
  logic misaligned;
  logic in_wait;
  logic timeout_hit;

  assign in_wait    = (state_q == ST_WAIT);
  assign accept     = (state_q == ST_IDLE) && valid && (mem_read || mem_write);
  assign misaligned = |(alu_result[2:0] & ALIGN_MASK);

`ifdef MEM_TIMEOUT_EN
  mem_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .clear  (accept && !misaligned),
    .active (in_wait),
    .expired(timeout_hit)
  );
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout_hit        = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    cause_d     = cause_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    exc_addr_d  = exc_addr_q;
    read_data_d = read_data_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          addr_d  = alu_result;
          wdata_d = write_data;
          // A store wins when both operation bits are set.
          we_d    = mem_write;
          if (misaligned) begin
            state_d    = ST_FAULT;
            cause_d    = CAUSE_MISALIGNED;
            exc_addr_d = alu_result;
          end else begin
            state_d = ST_WAIT;
            cause_d = CAUSE_NONE;
          end
        end
      end
      ST_WAIT: begin
        // An ack arriving in the timeout cycle still completes the access.
        if (dm_ack) begin
          if (!we_q) begin
            read_data_d = dm_rdata;
          end
          state_d = ST_DONE;
        end else if (timeout_hit) begin
          state_d    = ST_FAULT;
          cause_d    = CAUSE_BUS;
          exc_addr_d = addr_q;
        end
      end
      default: begin
        // DONE and FAULT are single-cycle; no acceptance here.
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cause_q     <= CAUSE_NONE;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      exc_addr_q  <= '0;
      read_data_q <= '0;
    end else begin
      state_q     <= state_d;
      cause_q     <= cause_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      exc_addr_q  <= exc_addr_d;
      read_data_q <= read_data_d;
    end
  end

  assign stall          = in_wait || accept;
  assign dm_req         = in_wait;
  assign dm_we          = in_wait && we_q;
  assign dm_addr        = in_wait ? addr_q : '0;
  assign dm_wdata       = in_wait ? wdata_q : '0;
  assign done           = (state_q == ST_DONE) || (state_q == ST_FAULT);
  assign exc_misaligned = (state_q == ST_FAULT) && (cause_q == CAUSE_MISALIGNED);
`ifdef MEM_TIMEOUT_EN
  assign exc_bus        = (state_q == ST_FAULT) && (cause_q == CAUSE_BUS);
`else
  assign exc_bus        = 1'b0;
`endif
  assign exc_addr       = exc_addr_q;
  assign read_data      = read_data_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// ----------------------------------------------------------------------------
// tb_mem_access_stage
// Self-checking bench: directed vector table, reset/idle/abort sequences and
// randomized transactions compared against a transaction-level model.
// ----------------------------------------------------------------------------
module tb_mem_access_stage;

  localparam int TO = 4;
`ifdef MEM_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        valid;
  logic        mem_read;
  logic        mem_write;
  logic [63:0] alu_result;
  logic [63:0] write_data;
  logic        stall;
  logic [63:0] read_data;
  logic        done;
  logic        exc_misaligned;
  logic        exc_bus;
  logic [63:0] exc_addr;
  logic        dm_req;
  logic        dm_we;
  logic [63:0] dm_addr;
  logic [63:0] dm_wdata;
  logic [63:0] dm_rdata;
  logic        dm_ack;

  always #5 clk = ~clk;

  mem_access_stage #(.TIMEOUT_CYCLES(TO)) dut (
    .clk           (clk),
    .reset         (reset),
    .valid         (valid),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .alu_result    (alu_result),
    .write_data    (write_data),
    .stall         (stall),
    .read_data     (read_data),
    .done          (done),
    .exc_misaligned(exc_misaligned),
    .exc_bus       (exc_bus),
    .exc_addr      (exc_addr),
    .dm_req        (dm_req),
    .dm_we         (dm_we),
    .dm_addr       (dm_addr),
    .dm_wdata      (dm_wdata),
    .dm_rdata      (dm_rdata),
    .dm_ack        (dm_ack)
  );

  int checks   = 0;
  int failures = 0;

  // Transaction-level model state: architecturally visible registers only.
  logic [63:0] model_rd  = '0;
  logic [63:0] model_exc = '0;

  typedef struct {
    int          stall_n;
    int          req_n;
    int          done_n;
    int          mis_n;
    int          bus_n;
    int          bad_bus;
    int          done_after;
    int          stall_after;
    logic [63:0] rdata;
    logic [63:0] exc;
  } obs_t;

  typedef struct {
    bit          rd;
    bit          wr;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] rdata;
    int          ack_at;
    int          exp_stall;
    int          exp_req;
    int          exp_mis;
    logic [63:0] exp_rd;
    logic [63:0] exp_exc;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Drive one instruction and observe it until done (bounded), then one idle cycle.
  task automatic run_txn(input bit rd, input bit wr, input logic [63:0] addr,
                         input logic [63:0] wdata, input logic [63:0] rdata,
                         input int ack_at, input bit noise, output obs_t o);
    int c;
    o = '{default: 0};
    @(negedge clk);
    valid = 1'b1; mem_read = rd; mem_write = wr;
    alu_result = addr; write_data = wdata; dm_rdata = rdata; dm_ack = 1'b0;
    c = 0;
    while (o.done_n == 0 && c < 80) begin
      #1;
      if (stall) o.stall_n++;
      if (dm_req) begin
        o.req_n++;
        if (dm_addr !== addr || dm_we !== wr || dm_wdata !== wdata) o.bad_bus++;
        dm_ack = (o.req_n == ack_at);
      end else begin
        dm_ack = noise && ($urandom_range(1, 0) == 1);
      end
      if (done) o.done_n++;
      if (exc_misaligned) o.mis_n++;
      if (exc_bus) o.bus_n++;
      @(negedge clk);
      c++;
    end
    dm_ack = 1'b0; valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    #1;
    o.done_after  = int'(done);
    o.stall_after = int'(stall);
    o.rdata       = read_data;
    o.exc         = exc_addr;
  endtask

  task automatic compare(input string tag, input obs_t o, input int e_stall, input int e_req,
                         input int e_mis, input int e_bus, input logic [63:0] e_rd,
                         input logic [63:0] e_exc);
    chk_int({tag, ".stall_cycles"}, o.stall_n, e_stall);
    chk_int({tag, ".req_cycles"}, o.req_n, e_req);
    chk_int({tag, ".done_pulses"}, o.done_n, 1);
    chk_int({tag, ".misaligned"}, o.mis_n, e_mis);
    chk_int({tag, ".bus"}, o.bus_n, e_bus);
    chk_int({tag, ".dm_bus_mismatch"}, o.bad_bus, 0);
    chk_int({tag, ".done_after"}, o.done_after, 0);
    chk_int({tag, ".stall_after"}, o.stall_after, 0);
    chk({tag, ".read_data"}, o.rdata, e_rd);
    chk({tag, ".exc_addr"}, o.exc, e_exc);
  endtask

  // Reference model: outcome of one transaction from the block's rules.
  task automatic model_txn(input bit wr, input logic [63:0] addr, input logic [63:0] rdata,
                           input int ack_at, output int e_stall, output int e_req,
                           output int e_mis, output int e_bus);
    e_mis = 0; e_bus = 0;
    if (addr % 8 != 0) begin
      e_stall = 1; e_req = 0; e_mis = 1; model_exc = addr;
    end else if (TO_EN && (ack_at == 0 || ack_at > TO)) begin
      e_req = TO; e_stall = TO + 1; e_bus = 1; model_exc = addr;
    end else begin
      e_req = ack_at; e_stall = ack_at + 1;
      if (!wr) model_rd = rdata;
    end
  endtask

  task automatic model_run(input string tag, input bit rd, input bit wr, input logic [63:0] addr,
                           input logic [63:0] wdata, input logic [63:0] rdata,
                           input int ack_at, input bit noise);
    obs_t o;
    int es, er, em, eb;
    run_txn(rd, wr, addr, wdata, rdata, ack_at, noise, o);
    model_txn(wr, addr, rdata, ack_at, es, er, em, eb);
    $display("txn %s rd=%0d wr=%0d addr=0x%0h ack_at=%0d stall=%0d req=%0d mis=%0d bus=%0d",
             tag, rd, wr, addr, ack_at, o.stall_n, o.req_n, o.mis_n, o.bus_n);
    compare(tag, o, es, er, em, eb, model_rd, model_exc);
  endtask

  initial begin
    obs_t o;
    int   idle_stall, idle_req, idle_done;

    vecs[0] = '{1'b1, 1'b0, 64'h40, 64'h0,    64'h1234, 1, 2, 1, 0, 64'h1234, 64'h0};
    vecs[1] = '{1'b0, 1'b1, 64'h88, 64'hDEAD, 64'h9999, 3, 4, 3, 0, 64'h1234, 64'h0};
    vecs[2] = '{1'b1, 1'b0, 64'h43, 64'h0,    64'h5,    1, 1, 0, 1, 64'h1234, 64'h43};
    vecs[3] = '{1'b1, 1'b1, 64'h10, 64'hBEEF, 64'h5555, 2, 3, 2, 0, 64'h1234, 64'h43};
    vecs[4] = '{1'b1, 1'b0, 64'h100, 64'h0,   64'hCAFE, 1, 2, 1, 0, 64'hCAFE, 64'h43};
    vecs[5] = '{1'b0, 1'b1, 64'h7,  64'h1,    64'h0,    1, 1, 0, 1, 64'hCAFE, 64'h7};

    reset = 1'b1; valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    alu_result = '0; write_data = '0; dm_rdata = '0; dm_ack = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("reset.stall", 64'(stall), 64'h0);
    chk("reset.read_data", read_data, 64'h0);
    chk("reset.done", 64'(done), 64'h0);
    chk("reset.exc", 64'({exc_misaligned, exc_bus}), 64'h0);
    chk("reset.exc_addr", exc_addr, 64'h0);
    chk("reset.dm_ctrl", 64'({dm_req, dm_we}), 64'h0);
    chk("reset.dm_addr", dm_addr, 64'h0);
    chk("reset.dm_wdata", dm_wdata, 64'h0);
    $display("txn reset outputs checked");

    // valid without a memory operation: nothing happens
    idle_stall = 0; idle_req = 0; idle_done = 0;
    @(negedge clk);
    valid = 1'b1;
    alu_result = 64'h80;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (stall) idle_stall++;
      if (dm_req) idle_req++;
      if (done) idle_done++;
      @(negedge clk);
    end
    valid = 1'b0;
    chk_int("nop.stall", idle_stall, 0);
    chk_int("nop.req", idle_req, 0);
    chk_int("nop.done", idle_done, 0);
    $display("txn valid-without-op stall=%0d req=%0d done=%0d", idle_stall, idle_req, idle_done);

    // directed vector table
    for (int i = 0; i < 6; i++) begin
      run_txn(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].rdata,
              vecs[i].ack_at, 1'b0, o);
      $display("txn vec%0d addr=0x%0h stall=%0d req=%0d mis=%0d rd=0x%0h exc=0x%0h",
               i, vecs[i].addr, o.stall_n, o.req_n, o.mis_n, o.rdata, o.exc);
      compare($sformatf("vec%0d", i), o, vecs[i].exp_stall, vecs[i].exp_req,
              vecs[i].exp_mis, 0, vecs[i].exp_rd, vecs[i].exp_exc);
    end
    model_rd  = 64'hCAFE;
    model_exc = 64'h7;

    // reset in the second WAIT cycle, followed by a late ack
    @(negedge clk);
    valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0;
    alu_result = 64'h20; dm_rdata = 64'h7777;
    @(negedge clk);
    #1;
    chk("abort.wait1_req", 64'(dm_req), 64'h1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; valid = 1'b0; mem_read = 1'b0; dm_ack = 1'b1;
    #1;
    chk("abort.req", 64'(dm_req), 64'h0);
    chk("abort.done", 64'(done), 64'h0);
    chk("abort.exc", 64'({exc_misaligned, exc_bus}), 64'h0);
    chk("abort.read_data", read_data, 64'h0);
    chk("abort.exc_addr", exc_addr, 64'h0);
    @(negedge clk);
    dm_ack = 1'b0;
    #1;
    chk("abort.late_req", 64'(dm_req), 64'h0);
    chk("abort.late_done", 64'(done), 64'h0);
    chk("abort.late_read_data", read_data, 64'h0);
    $display("txn abort-in-wait req=%0d done=%0d read_data=0x%0h", dm_req, done, read_data);
    model_rd  = '0;
    model_exc = '0;

    // long wait: indefinite without timeout, bus fault with it
    model_run("long_wait", 1'b1, 1'b0, 64'h200, 64'h0, 64'hABCD, 30, 1'b0);
    // ack exactly at the timeout boundary completes normally
    model_run("ack_at_limit", 1'b1, 1'b0, 64'h208, 64'h0, 64'h4444, TO, 1'b0);
    // no ack at all (timeout build) / very late ack (default build)
    model_run("no_ack", 1'b0, 1'b1, 64'h300, 64'h55, 64'h0, TO_EN ? 0 : 9, 1'b0);

    // randomized transactions with spurious acks outside WAIT
    for (int i = 0; i < 40; i++) begin
      int          op;
      logic [63:0] addr;
      op   = int'($urandom_range(2, 0));
      addr = {$urandom, $urandom};
      if ($urandom_range(1, 0) == 1) addr[2:0] = 3'b000;
      model_run($sformatf("rnd%0d", i), op != 1, op != 0, addr, {$urandom, $urandom},
                {$urandom, $urandom}, int'($urandom_range(6, 1)), 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
